// File: rtl/mode_ctrl.sv
// Top-level mode sequencer: cycles display modes, steps clock/timer edit fields,
// and abandons an edit after a configurable idle period.
module mode_ctrl #(
  parameter int P_TIMEOUT_CYC = 1_000_000_000
) (
  input  logic       iClk,
  input  logic       iRsn,
  input  logic       iBtn_Mode,
  input  logic       iBtn_Set,
  input  logic       iBtn_Edit,
  input  logic       iTimer_Run,
  output logic [3:0] oMode,
  output logic [1:0] oCLK_Set,
  output logic [1:0] oTIMER_Set,
  output logic       oSet_Active,
  output logic       oMode_Chg
);

  typedef enum logic [3:0] {
    S_CLK   = 4'b0000,
    S_SW    = 4'b0001,
    S_TIMER = 4'b0010,
    S_ULTRA = 4'b0100,
    S_DHT   = 4'b1000
  } modeT;

  localparam logic [29:0] LP_LAST_IDLE = 30'(P_TIMEOUT_CYC - 1);

  modeT        stateReg, stateNext;
  logic [1:0]  clkSetReg, clkSetNext;
  logic [1:0]  timerSetReg, timerSetNext;
  logic        setActiveReg, setActiveNext;
  logic        modeChgReg, modeChgNext;
  logic [29:0] idleCntReg, idleCntNext;
  logic        anyPulse;
  logic        timeoutHit;

  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      stateReg     <= S_CLK;
      clkSetReg    <= 2'b00;
      timerSetReg  <= 2'b00;
      setActiveReg <= 1'b0;
      modeChgReg   <= 1'b0;
      idleCntReg   <= '0;
    end else begin
      stateReg     <= stateNext;
      clkSetReg    <= clkSetNext;
      timerSetReg  <= timerSetNext;
      setActiveReg <= setActiveNext;
      modeChgReg   <= modeChgNext;
      idleCntReg   <= idleCntNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    clkSetNext   = clkSetReg;
    timerSetNext = timerSetReg;
    modeChgNext  = 1'b0;
    anyPulse     = iBtn_Mode | iBtn_Set | iBtn_Edit;
    timeoutHit   = setActiveReg && !anyPulse && (idleCntReg == LP_LAST_IDLE);

    // Set wins over mode when both arrive together; the mode pulse is dropped.
    if (iBtn_Set) begin
      case (stateReg)
        S_CLK:   clkSetNext = clkSetReg + 2'd1;
        S_TIMER: begin
          if (!(timerSetReg == 2'b00 && iTimer_Run))
            timerSetNext = timerSetReg + 2'd1;
        end
        default: ;
      endcase
    end else if (iBtn_Mode && !setActiveReg) begin
      modeChgNext = 1'b1;
      case (stateReg)
        S_CLK:   stateNext = S_SW;
        S_SW:    stateNext = S_TIMER;
        S_TIMER: stateNext = S_ULTRA;
        S_ULTRA: stateNext = S_DHT;
        default: stateNext = S_CLK;
      endcase
    end else if (timeoutHit) begin
      clkSetNext   = 2'b00;
      timerSetNext = 2'b00;
    end

    if (!setActiveReg || anyPulse || timeoutHit)
      idleCntNext = '0;
    else
      idleCntNext = idleCntReg + 30'd1;

    setActiveNext = (clkSetNext != 2'b00) | (timerSetNext != 2'b00);
  end

  assign oMode       = stateReg;
  assign oCLK_Set    = clkSetReg;
  assign oTIMER_Set  = timerSetReg;
  assign oSet_Active = setActiveReg;
  assign oMode_Chg   = modeChgReg;

endmodule
